// File: rtl/strip_alloc_sched.sv
// First-fit strip allocator: scans strips 1..13 one per cycle for room,
// returns strip id, x offset and y position, and tracks per-strip fill.

module id_to_y (
  input  logic [3:0] id,
  output logic [7:0] y
);
  always_comb begin
    y = 8'd0;
    case (id)
      4'd1:  y = 8'd0;
      4'd2:  y = 8'd8;
      4'd3:  y = 8'd16;
      4'd4:  y = 8'd25;
      4'd5:  y = 8'd32;
      4'd6:  y = 8'd42;
      4'd7:  y = 8'd48;
      4'd8:  y = 8'd59;
      4'd9:  y = 8'd64;
      4'd10: y = 8'd76;
      4'd11: y = 8'd80;
      4'd12: y = 8'd96;
      4'd13: y = 8'd112;
      default: y = 8'd0;
    endcase
  end
endmodule

module strip_alloc_sched #(
  parameter int NUM_STRIPS = 13,
  parameter int STRIP_W    = 128,
  parameter int W_BITS     = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [W_BITS-1:0] req_width_i,
  input  logic              clear_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic              resp_ok_o,
  output logic [3:0]        resp_id_o,
  output logic [W_BITS-1:0] resp_x_o,
  output logic [7:0]        resp_y_o,
  output logic              full_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; valid, once raised, holds its payload stable until then.
  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

  localparam logic [W_BITS:0]   STRIP_W_EXT = (W_BITS+1)'(STRIP_W);
  localparam logic [3:0]        LAST_ID     = 4'(NUM_STRIPS);

  state_t            state_q, state_d;
  logic [3:0]        ptr_q;
  logic [W_BITS-1:0] width_q;
  logic [W_BITS-1:0] fill_q [NUM_STRIPS];
  logic              resp_ok_q;
  logic [3:0]        resp_id_q;
  logic [W_BITS-1:0] resp_x_q;
  logic              full_q;

  logic [W_BITS-1:0] cur_fill;
  logic [W_BITS:0]   sum;
  logic              fits;
  logic              illegal;
  logic              all_full;
  logic [7:0]        y_raw;
  logic [3:0]        ptr_idx;

  assign ptr_idx  = ptr_q - 4'd1;
  assign cur_fill = fill_q[ptr_idx];
  // Widened by one bit so fill + width can never wrap.
  assign sum      = {1'b0, cur_fill} + {1'b0, width_q};
  assign fits     = (sum <= STRIP_W_EXT);
  assign illegal  = (req_width_i == '0) || ({1'b0, req_width_i} > STRIP_W_EXT);

  always_comb begin
    all_full = 1'b1;
    for (int k = 0; k < NUM_STRIPS; k++) begin
      if ({1'b0, fill_q[k]} != STRIP_W_EXT) all_full = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!clear_i && req_valid_i) state_d = illegal ? RESP : SEARCH;
      end
      SEARCH: begin
        if (fits || ptr_q == LAST_ID) state_d = RESP;
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ptr_q     <= 4'd1;
      width_q   <= '0;
      resp_ok_q <= 1'b0;
      resp_id_q <= '0;
      resp_x_q  <= '0;
      full_q    <= 1'b0;
      for (int k = 0; k < NUM_STRIPS; k++) fill_q[k] <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= all_full;
      case (state_q)
        IDLE: begin
          if (clear_i) begin
            for (int k = 0; k < NUM_STRIPS; k++) fill_q[k] <= '0;
          end else if (req_valid_i) begin
            width_q   <= req_width_i;
            ptr_q     <= 4'd1;
            resp_ok_q <= 1'b0;
            resp_id_q <= '0;
            resp_x_q  <= '0;
          end
        end
        SEARCH: begin
          if (fits) begin
            resp_ok_q        <= 1'b1;
            resp_id_q        <= ptr_q;
            resp_x_q         <= cur_fill;
            fill_q[ptr_idx]  <= sum[W_BITS-1:0];
          end else if (ptr_q == LAST_ID) begin
            resp_ok_q <= 1'b0;
            resp_id_q <= '0;
            resp_x_q  <= '0;
          end else begin
            ptr_q <= ptr_q + 4'd1;
          end
        end
        RESP: begin
          // Drop the payload once consumed so idle outputs read as zero.
          if (resp_ready_i) begin
            resp_ok_q <= 1'b0;
            resp_id_q <= '0;
            resp_x_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  id_to_y u_id_to_y (
    .id (resp_id_q),
    .y  (y_raw)
  );

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_ok_o    = resp_ok_q;
  assign resp_id_o    = resp_id_q;
  assign resp_x_o     = resp_x_q;
  assign resp_y_o     = resp_ok_q ? y_raw : 8'd0;
  assign full_o       = full_q;

endmodule

// File: tb/tb_strip_alloc_sched.sv
// Directed bench for strip_alloc_sched: vector table of single requests
// plus hand sequences for fill-up, backpressure, clear and reset.

module tb_strip_alloc_sched;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [7:0] req_width_i;
  logic       clear_i;
  logic       resp_valid_o;
  logic       resp_ready_i;
  logic       resp_ok_o;
  logic [3:0] resp_id_o;
  logic [7:0] resp_x_o;
  logic [7:0] resp_y_o;
  logic       full_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int w; int edges; int ok; int id; int x; int y;
  } vec_t;

  vec_t vecs[7];
  int   ytab[13];

  always #5 clk_i = ~clk_i;

  strip_alloc_sched dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_width_i  (req_width_i),
    .clear_i      (clear_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_ok_o    (resp_ok_o),
    .resp_id_o    (resp_id_o),
    .resp_x_o     (resp_x_o),
    .resp_y_o     (resp_y_o),
    .full_o       (full_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_valid_i = 1'b0; clear_i = 1'b0; resp_ready_i = 1'b0; req_width_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Presents one request at a negedge, counts rising edges until the
  // response appears, checks it, then completes the response handshake.
  task automatic do_req(input string tag, input int w, input int edges,
                        input int ok, input int id, input int x, input int y);
    int n;
    chk({tag, ".ready"}, int'(req_ready_o), 1);
    req_width_i = 8'(w);
    req_valid_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk_i);
      n++;
      @(negedge clk_i);
      req_valid_i = 1'b0;
    end while (!resp_valid_o && n < 40);
    chk({tag, ".latency"}, n, edges);
    chk({tag, ".ok"}, int'(resp_ok_o), ok);
    chk({tag, ".id"}, int'(resp_id_o), id);
    chk({tag, ".x"}, int'(resp_x_o), x);
    chk({tag, ".y"}, int'(resp_y_o), y);
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    chk({tag, ".done"}, int'(resp_valid_o), 0);
  endtask

  initial begin
    vecs[0] = '{w: 100, edges: 2, ok: 1, id: 1, x: 0,   y: 0};
    vecs[1] = '{w: 50,  edges: 3, ok: 1, id: 2, x: 0,   y: 8};
    vecs[2] = '{w: 28,  edges: 2, ok: 1, id: 1, x: 100, y: 0};
    vecs[3] = '{w: 0,   edges: 1, ok: 0, id: 0, x: 0,   y: 0};
    vecs[4] = '{w: 129, edges: 1, ok: 0, id: 0, x: 0,   y: 0};
    vecs[5] = '{w: 29,  edges: 3, ok: 1, id: 2, x: 50,  y: 8};
    vecs[6] = '{w: 255, edges: 1, ok: 0, id: 0, x: 0,   y: 0};
    ytab = '{0, 8, 16, 25, 32, 42, 48, 59, 64, 76, 80, 96, 112};

    do_reset();
    chk("rst.ready", int'(req_ready_o), 1);
    chk("rst.valid", int'(resp_valid_o), 0);
    chk("rst.ok", int'(resp_ok_o), 0);
    chk("rst.id", int'(resp_id_o), 0);
    chk("rst.x", int'(resp_x_o), 0);
    chk("rst.y", int'(resp_y_o), 0);
    chk("rst.full", int'(full_o), 0);

    for (int i = 0; i < 7; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].w, vecs[i].edges,
             vecs[i].ok, vecs[i].id, vecs[i].x, vecs[i].y);
    end

    // Fill every strip exactly, then a 1-wide item cannot fit anywhere.
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      do_req($sformatf("fill%0d", k), 128, k + 1, 1, k, 0, ytab[k-1]);
    end
    @(negedge clk_i);
    chk("full.set", int'(full_o), 1);
    do_req("nofit", 1, 14, 0, 0, 0, 0);

    // Clear beats a simultaneous request.
    clear_i = 1'b1; req_valid_i = 1'b1; req_width_i = 8'd5;
    @(posedge clk_i);
    @(negedge clk_i);
    clear_i = 1'b0; req_valid_i = 1'b0;
    chk("clr.ready", int'(req_ready_o), 1);
    chk("clr.valid", int'(resp_valid_o), 0);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("clr.full", int'(full_o), 0);
    do_req("clr.after", 128, 2, 1, 1, 0, 0);

    // Backpressure: response held while a new request is presented.
    do_reset();
    req_width_i = 8'd10; req_valid_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    req_width_i = 8'd20;
    chk("bp.valid", int'(resp_valid_o), 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk($sformatf("bp.hold%0d.valid", c), int'(resp_valid_o), 1);
      chk($sformatf("bp.hold%0d.ready", c), int'(req_ready_o), 0);
      chk($sformatf("bp.hold%0d.id", c), int'(resp_id_o), 1);
      chk($sformatf("bp.hold%0d.x", c), int'(resp_x_o), 0);
      chk($sformatf("bp.hold%0d.ok", c), int'(resp_ok_o), 1);
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    chk("bp.released", int'(resp_valid_o), 0);
    chk("bp.idle", int'(req_ready_o), 1);
    do_req("bp.next", 20, 2, 1, 1, 10, 0);

    // Reset in the middle of a search drops the request and all fills.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      do_req($sformatf("pre%0d", k), 128, k + 1, 1, k, 0, ytab[k-1]);
    end
    req_width_i = 8'd5; req_valid_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("mid.searching", int'(req_ready_o), 0);
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk($sformatf("mid.noresp%0d", c), int'(resp_valid_o), 0);
    end
    chk("mid.ready", int'(req_ready_o), 1);
    do_req("mid.after", 128, 2, 1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
